// File: rtl/multiplier_core_pkg.sv
// Shared math-box constants for the sequential shift-add multiplier.
package multiplier_core_pkg;

    // Number of shift-add steps, one per multiplier bit
    localparam int MULT_STEPS = 16;

    // Counter terminal value: start at 1, steps on even counts 2..32, done at 33
    localparam int MULT_TIMING = 33;

    // Sequencing counter width and the counter values the core compares against
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(MULT_TIMING);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MULT_TIMING - 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(1);

    // Control register bit selecting accumulate mode
    localparam int CTRL_ACC = 0;

endpackage

// File: rtl/multiplier_core_step.sv
// One combinational shift-add step of the 16x16 unsigned multiplier.
// P holds the partial product in its upper half and the remaining
// multiplier bits in its lower half; each step consumes P[0].
module mult_step
    import multiplier_core_pkg::*;
(
    input  logic [31:0] p,
    input  logic [15:0] mcand,
    output logic [31:0] p_next
);

    logic [16:0] sum;

    // Add the multiplicand into the upper half when the current bit is set, then shift right
    always_comb begin
        sum = {1'b0, p[31:16]} + {1'b0, mcand};
        if (p[0]) begin
            p_next = {sum, p[15:1]};
        end else begin
            p_next = {1'b0, p[31:1]};
        end
    end

endmodule

// File: rtl/multiplier_core.sv
// Star Wars math box multiplier: byte-loaded operands, 16-step shift-add
// sequence started by the falling edge of the multiplier-low write, with
// an optional 32-bit wrapping accumulator. The multiplier low byte has no
// separate holding register: it is taken straight from the bus into the
// working product register, which is the only place it is ever used.
module multiplier_core
    import multiplier_core_pkg::*;
(
    input  logic       clk_6,
    input  logic       reset_n,
    input  logic       MCDH_WR,
    input  logic       MCDL_WR,
    input  logic       MPRH_WR,
    input  logic       MPRL_WR,
    input  logic       CTRL_WR,
    input  logic       ACC_CLR_WR,
    input  logic [7:0] cpu_data_in,
    output logic [7:0] P3_DATA_OUT,
    output logic [7:0] P2_DATA_OUT,
    output logic [7:0] P1_DATA_OUT,
    output logic [7:0] P0_DATA_OUT,
    output logic       BUSY
);

    logic [7:0]       mcdh;
    logic [7:0]       mcdl;
    logic [7:0]       mprh;
    logic             ctrl_acc;
    logic             mprl_wr_q;
    logic [15:0]      mcand;
    logic [31:0]      p;
    logic [31:0]      p_next;
    logic [31:0]      acc;
    logic [31:0]      acc_sum;
    logic [31:0]      result;
    logic             acc_mode;
    logic [CNT_W-1:0] counter;
    logic             start;
    logic             running;
    logic             step_en;
    logic             done;

    mult_step u_step (
        .p      (p),
        .mcand  (mcand),
        .p_next (p_next)
    );

    // Decode start, iteration, step and completion from the strobe history and counter
    always_comb begin
        start   = !MPRL_WR && mprl_wr_q;
        running = !MPRL_WR && !start && (counter < CNT_DONE);
        step_en = running && !counter[0];
        done    = running && (counter == CNT_LAST);
        acc_sum = acc + p_next;
    end

    // CPU-visible byte registers and the strobe edge detector
    always_ff @(posedge clk_6 or negedge reset_n) begin
        if (!reset_n) begin
            mcdh      <= '0;
            mcdl      <= '0;
            mprh      <= '0;
            ctrl_acc  <= 1'b0;
            mprl_wr_q <= 1'b0;
        end else begin
            mprl_wr_q <= MPRL_WR;
            if (MCDH_WR) mcdh <= cpu_data_in;
            if (MCDL_WR) mcdl <= cpu_data_in;
            if (MPRH_WR) mprh <= cpu_data_in;
            if (CTRL_WR) ctrl_acc <= cpu_data_in[CTRL_ACC];
        end
    end

    // Sequencing counter and BUSY; a multiplier-low write parks the counter so an in-flight run aborts
    always_ff @(posedge clk_6 or negedge reset_n) begin
        if (!reset_n) begin
            counter <= CNT_DONE;
            BUSY    <= 1'b0;
        end else begin
            if (MPRL_WR) begin
                counter <= CNT_DONE;
            end else if (start) begin
                counter <= CNT_START;
                BUSY    <= 1'b1;
            end else if (running) begin
                counter <= counter + CNT_W'(1);
                if (done) BUSY <= 1'b0;
            end
        end
    end

    // Working operands: snapshot on the multiplier-low write so later byte writes cannot disturb the run
    always_ff @(posedge clk_6 or negedge reset_n) begin
        if (!reset_n) begin
            mcand    <= '0;
            p        <= '0;
            acc_mode <= 1'b0;
        end else if (MPRL_WR) begin
            mcand    <= {mcdh, mcdl};
            p        <= {16'h0000, mprh, cpu_data_in};
            acc_mode <= ctrl_acc;
        end else if (step_en) begin
            p <= p_next;
        end
    end

    // Accumulator and visible result; a clear coinciding with completion wins over the add
    always_ff @(posedge clk_6 or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            result <= '0;
        end else if (done && acc_mode) begin
            if (ACC_CLR_WR) begin
                acc    <= p_next;
                result <= p_next;
            end else begin
                acc    <= acc_sum;
                result <= acc_sum;
            end
        end else begin
            if (ACC_CLR_WR) acc <= '0;
            if (done) result <= p_next;
        end
    end

    assign P3_DATA_OUT = result[31:24];
    assign P2_DATA_OUT = result[23:16];
    assign P1_DATA_OUT = result[15:8];
    assign P0_DATA_OUT = result[7:0];

endmodule

// File: tb/tb_multiplier_core.sv
// Directed self-checking bench for multiplier_core.
module tb_multiplier_core;

    localparam int S_MCDH = 0;
    localparam int S_MCDL = 1;
    localparam int S_MPRH = 2;
    localparam int S_MPRL = 3;
    localparam int S_CTRL = 4;
    localparam int S_CLR  = 5;

    logic       clk_6;
    logic       reset_n;
    logic       MCDH_WR;
    logic       MCDL_WR;
    logic       MPRH_WR;
    logic       MPRL_WR;
    logic       CTRL_WR;
    logic       ACC_CLR_WR;
    logic [7:0] cpu_data_in;
    logic [7:0] P3_DATA_OUT;
    logic [7:0] P2_DATA_OUT;
    logic [7:0] P1_DATA_OUT;
    logic [7:0] P0_DATA_OUT;
    logic       BUSY;

    int total;
    int bad;

    multiplier_core dut (
        .clk_6       (clk_6),
        .reset_n     (reset_n),
        .MCDH_WR     (MCDH_WR),
        .MCDL_WR     (MCDL_WR),
        .MPRH_WR     (MPRH_WR),
        .MPRL_WR     (MPRL_WR),
        .CTRL_WR     (CTRL_WR),
        .ACC_CLR_WR  (ACC_CLR_WR),
        .cpu_data_in (cpu_data_in),
        .P3_DATA_OUT (P3_DATA_OUT),
        .P2_DATA_OUT (P2_DATA_OUT),
        .P1_DATA_OUT (P1_DATA_OUT),
        .P0_DATA_OUT (P0_DATA_OUT),
        .BUSY        (BUSY)
    );

    // Free-running clock
    initial begin
        clk_6 = 1'b0;
        forever #5 clk_6 = ~clk_6;
    end

    function automatic logic [31:0] resultBus();
        return {P3_DATA_OUT, P2_DATA_OUT, P1_DATA_OUT, P0_DATA_OUT};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge: raise one strobe for one rising edge, drop it on the next falling edge
    task automatic applyStimulus(input int sel, input logic [7:0] data);
        cpu_data_in = data;
        case (sel)
            S_MCDH:  MCDH_WR    = 1'b1;
            S_MCDL:  MCDL_WR    = 1'b1;
            S_MPRH:  MPRH_WR    = 1'b1;
            S_MPRL:  MPRL_WR    = 1'b1;
            S_CTRL:  CTRL_WR    = 1'b1;
            default: ACC_CLR_WR = 1'b1;
        endcase
        @(negedge clk_6);
        MCDH_WR    = 1'b0;
        MCDL_WR    = 1'b0;
        MPRH_WR    = 1'b0;
        MPRL_WR    = 1'b0;
        CTRL_WR    = 1'b0;
        ACC_CLR_WR = 1'b0;
    endtask

    // Returns on the falling edge just after MPRL_WR drops
    task automatic loadOperands(input logic [15:0] mcand, input logic [15:0] mplier);
        applyStimulus(S_MCDH, mcand[15:8]);
        applyStimulus(S_MCDL, mcand[7:0]);
        applyStimulus(S_MPRH, mplier[15:8]);
        applyStimulus(S_MPRL, mplier[7:0]);
    endtask

    // Counts falling edges until BUSY drops (bounded), tracking BUSY length and result stability
    task automatic waitDone(input logic [31:0] prev, output int cycles, output int busyCount, output logic held);
        cycles    = 0;
        busyCount = 0;
        held      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_6);
            cycles++;
            if (BUSY) begin
                busyCount++;
                if (resultBus() !== prev) held = 1'b0;
            end else begin
                break;
            end
        end
    endtask

    // Single linear sequence of directed steps
    initial begin
        int          cyc;
        int          bcnt;
        logic        held;
        logic [31:0] prev;

        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        MCDH_WR     = 1'b0;
        MCDL_WR     = 1'b0;
        MPRH_WR     = 1'b0;
        MPRL_WR     = 1'b0;
        CTRL_WR     = 1'b0;
        ACC_CLR_WR  = 1'b0;
        cpu_data_in = 8'h00;

        repeat (3) @(negedge clk_6);
        checkOutput("reset_result", resultBus(), 32'h0000_0000);
        checkOutput("reset_busy", {31'b0, BUSY}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk_6);

        // 0x1234 x 0x5678, plain mode
        applyStimulus(S_CTRL, 8'h00);
        prev = resultBus();
        loadOperands(16'h1234, 16'h5678);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("basic_latency", cyc, 33);
        checkOutput("basic_busy_len", bcnt, 32);
        checkOutput("basic_held", {31'b0, held}, 32'd1);
        checkOutput("basic_result", resultBus(), 32'h0626_0060);
        checkOutput("basic_p3", {24'h0, P3_DATA_OUT}, 32'h06);
        checkOutput("basic_p0", {24'h0, P0_DATA_OUT}, 32'h60);

        // 0xFFFF x 0xFFFF; byte writes in flight must not disturb it
        prev = resultBus();
        loadOperands(16'hFFFF, 16'hFFFF);
        applyStimulus(S_MCDH, 8'h00);
        applyStimulus(S_MPRH, 8'h00);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("max_latency", cyc, 31);
        checkOutput("max_held", {31'b0, held}, 32'd1);
        checkOutput("max_result", resultBus(), 32'hFFFE_0001);

        // Zero multiplicand
        prev = resultBus();
        loadOperands(16'h0000, 16'hABCD);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("zero_result", resultBus(), 32'h0000_0000);

        // Accumulate mode: 2x3 twice
        applyStimulus(S_CTRL, 8'h01);
        applyStimulus(S_CLR, 8'h00);
        prev = resultBus();
        loadOperands(16'h0002, 16'h0003);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("acc_first", resultBus(), 32'h0000_0006);
        prev = resultBus();
        loadOperands(16'h0002, 16'h0003);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("acc_second", resultBus(), 32'h0000_000C);

        // Clear alone leaves RESULT untouched
        applyStimulus(S_CLR, 8'h00);
        @(negedge clk_6);
        checkOutput("clr_keeps_result", resultBus(), 32'h0000_000C);

        // Accumulate wrap: 0xFFFF x 0xFFFF twice
        prev = resultBus();
        loadOperands(16'hFFFF, 16'hFFFF);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("wrap_first", resultBus(), 32'hFFFE_0001);
        prev = resultBus();
        loadOperands(16'hFFFF, 16'hFFFF);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("wrap_second", resultBus(), 32'hFFFC_0002);

        // Restart at counter 10 with 0x0010 x 0x0010; the aborted product must not be accumulated
        applyStimulus(S_CLR, 8'h00);
        loadOperands(16'h1234, 16'h5678);
        applyStimulus(S_MCDH, 8'h00);
        applyStimulus(S_MCDL, 8'h10);
        applyStimulus(S_MPRH, 8'h00);
        repeat (7) @(negedge clk_6);
        checkOutput("restart_busy_before", {31'b0, BUSY}, 32'd1);
        prev = resultBus();
        applyStimulus(S_MPRL, 8'h10);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("restart_latency", cyc, 33);
        checkOutput("restart_held", {31'b0, held}, 32'd1);
        checkOutput("restart_result", resultBus(), 32'h0000_0100);

        // Reset asserted at counter 20
        loadOperands(16'h1234, 16'h5678);
        repeat (20) @(negedge clk_6);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_result", resultBus(), 32'h0000_0000);
        checkOutput("midreset_busy", {31'b0, BUSY}, 32'd0);
        @(negedge clk_6);
        reset_n = 1'b1;
        @(negedge clk_6);
        prev = resultBus();
        loadOperands(16'h0003, 16'h0005);
        waitDone(prev, cyc, bcnt, held);
        checkOutput("post_reset_latency", cyc, 33);
        checkOutput("post_reset_result", resultBus(), 32'h0000_000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
